fracnet_sdiv_28s_12s_16: RTL and testbench

- Iterative signed divider: the inverse operation of the 16s x 12s -> 28-bit pipelined multiplier used in the FracNet datapath.
- Divides a 28-bit signed dividend, typically a widened MAC/product, by a 12-bit signed divisor, typically a scale or BN factor.
- Returns a saturated 16-bit signed quotient and a 12-bit signed remainder.
- Valid/ready handshake on both sides, one bit per cycle (restoring algorithm), gated by ce like the other arithmetic cores.

---
 rtl/fracnet_sdiv_28s_12s_16_if.sv | 28 ++
 rtl/fracnet_sdiv_28s_12s_16.sv | 163 ++++++++++++++++
 tb/tb_fracnet_sdiv_28s_12s_16.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fracnet_sdiv_28s_12s_16_if.sv
// Handshake bundle for the FracNet iterative signed divider.
// Carries the operand (request) side and the result (response) side.
interface fracnet_sdiv_28s_12s_16_if #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 12,
  parameter int QUOT_W     = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [QUOT_W-1:0]     quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         ovf;
  logic                         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, div_by_zero
  );
endinterface

// File: rtl/fracnet_sdiv_28s_12s_16.sv
// Iterative restoring signed divider, 28s / 12s -> saturated 16s quotient
// and 12s remainder, one quotient bit per enabled cycle.
// Optional macro FRACNET_DIV_ROUND_EN: round the quotient half away from zero.
module fracnet_sdiv_28s_12s_16 #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 12,
  parameter int QUOT_W     = 16
) (
  input logic clk,
  input logic reset,
  input logic ce,
  fracnet_sdiv_28s_12s_16_if.slave bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W:0] POS_LIM = (DIVIDEND_W+1)'((1 << (QUOT_W-1)) - 1);
  localparam logic [DIVIDEND_W:0] NEG_LIM = (DIVIDEND_W+1)'(1 << (QUOT_W-1));
  localparam logic [QUOT_W-1:0]   Q_MAX   = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]   Q_MIN   = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state, state_next;
  logic [DIVISOR_W:0]      part_rem;
  logic [DIVIDEND_W-1:0]   quo_acc;
  logic [DIVISOR_W-1:0]    dvs_mag;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    neg_dividend;
  logic                    neg_result;
  logic                    dz_pending;
  logic [QUOT_W-1:0]       quotient_q;
  logic [DIVISOR_W-1:0]    remainder_q;
  logic                    ovf_q;
  logic                    dz_q;

  logic                    accept;
  logic [DIVIDEND_W-1:0]   dividend_u, dividend_mag;
  logic [DIVISOR_W-1:0]    divisor_u, divisor_mag;
  logic [DIVISOR_W:0]      shifted, dvs_ext, diff;
  logic                    trial_ge;
  logic [DIVIDEND_W:0]     mag_fix;
  logic [QUOT_W-1:0]       fix_q;
  logic [DIVISOR_W-1:0]    fix_r;
  logic                    fix_ovf;

  assign accept        = ce && bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.ovf         = ovf_q;
  assign bus.div_by_zero = dz_q;

  // Operand magnitudes; the most negative values map to 2^(W-1) unsigned.
  always_comb begin
    dividend_u   = bus.dividend;
    divisor_u    = bus.divisor;
    dividend_mag = dividend_u[DIVIDEND_W-1] ? (~dividend_u + DIVIDEND_W'(1)) : dividend_u;
    divisor_mag  = divisor_u[DIVISOR_W-1] ? (~divisor_u + DIVISOR_W'(1)) : divisor_u;
  end

  // One restoring step; a set top remainder bit means the shifted value already exceeds the divisor.
  always_comb begin
    shifted  = {part_rem[DIVISOR_W-1:0], quo_acc[DIVIDEND_W-1]};
    dvs_ext  = {1'b0, dvs_mag};
    diff     = shifted - dvs_ext;
    trial_ge = part_rem[DIVISOR_W] || (shifted >= dvs_ext);
  end

  // Sign application, optional rounding and saturation of the finished magnitude.
  always_comb begin
`ifdef FRACNET_DIV_ROUND_EN
    mag_fix = {1'b0, quo_acc}
            + (DIVIDEND_W+1)'({part_rem[DIVISOR_W-1:0], 1'b0} >= dvs_ext);
`else
    mag_fix = {1'b0, quo_acc};
`endif
    fix_q   = '0;
    fix_r   = '0;
    fix_ovf = 1'b0;
    if (dz_pending) begin
      fix_q = neg_dividend ? Q_MIN : Q_MAX;
    end else begin
      fix_r = neg_dividend ? (~part_rem[DIVISOR_W-1:0] + DIVISOR_W'(1))
                           : part_rem[DIVISOR_W-1:0];
      if (neg_result) begin
        if (mag_fix > NEG_LIM) begin
          fix_q   = Q_MIN;
          fix_ovf = 1'b1;
        end else begin
          fix_q = ~mag_fix[QUOT_W-1:0] + QUOT_W'(1);
        end
      end else begin
        if (mag_fix > POS_LIM) begin
          fix_q   = Q_MAX;
          fix_ovf = 1'b1;
        end else begin
          fix_q = mag_fix[QUOT_W-1:0];
        end
      end
    end
  end

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; nothing moves while ce is low.
  always_comb begin
    state_next = state;
    if (ce) begin
      case (state)
        IDLE: if (bus.in_valid) state_next = (bus.divisor == '0) ? FIX : CALC;
        CALC: if (bit_cnt == '0) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (bus.out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, shift/subtract iterations, result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      part_rem     <= '0;
      quo_acc      <= '0;
      dvs_mag      <= '0;
      bit_cnt      <= '0;
      neg_dividend <= 1'b0;
      neg_result   <= 1'b0;
      dz_pending   <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      ovf_q        <= 1'b0;
      dz_q         <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: if (accept) begin
          neg_dividend <= bus.dividend[DIVIDEND_W-1];
          neg_result   <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
          quo_acc      <= dividend_mag;
          dvs_mag      <= divisor_mag;
          part_rem     <= '0;
          bit_cnt      <= CNT_W'(DIVIDEND_W-1);
          dz_pending   <= (bus.divisor == '0);
        end
        CALC: begin
          part_rem <= trial_ge ? diff : shifted;
          quo_acc  <= {quo_acc[DIVIDEND_W-2:0], trial_ge};
          bit_cnt  <= bit_cnt - CNT_W'(1);
        end
        FIX: begin
          quotient_q  <= fix_q;
          remainder_q <= fix_r;
          ovf_q       <= fix_ovf;
          dz_q        <= dz_pending;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fracnet_sdiv_28s_12s_16.sv
// Directed bench for fracnet_sdiv_28s_12s_16: arithmetic, saturation,
// divide-by-zero, backpressure, clock-enable stalls and mid-op reset.
module tb_fracnet_sdiv_28s_12s_16;
  logic clk = 1'b0;
  logic reset;
  logic ce;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   lat;

`ifdef FRACNET_DIV_ROUND_EN
  localparam int Q_1000_7 = 143;
`else
  localparam int Q_1000_7 = 142;
`endif

  fracnet_sdiv_28s_12s_16_if bus ();

  fracnet_sdiv_28s_12s_16 dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation and count enabled+stalled edges from the accept edge (=1) to out_valid.
  task automatic applyStimulus(input logic signed [27:0] a, input logic signed [11:0] b,
                               input int ce_drop_at, output int latency);
    check("in_ready_idle", bus.in_ready, 1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 28'sh5A5A5A5;
    bus.divisor  = 12'sh3C3;
    latency = 1;
    while (!bus.out_valid && latency < 100) begin
      if (latency == ce_drop_at)     ce = 1'b0;
      if (latency == ce_drop_at + 5) ce = 1'b1;
      @(posedge clk); #1;
      latency++;
    end
  endtask

  // Compare the presented result, then consume it.
  task automatic checkOutput(input string tag, input int exp_q, input int exp_r,
                             input int exp_ovf, input int exp_dz, input int exp_lat,
                             input int latency);
    check({tag, "_latency"}, latency, exp_lat);
    check({tag, "_out_valid"}, bus.out_valid, 1);
    check({tag, "_quotient"}, bus.quotient, exp_q);
    check({tag, "_remainder"}, bus.remainder, exp_r);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    check({tag, "_dz"}, bus.div_by_zero, exp_dz);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_released"}, bus.out_valid, 0);
  endtask

  initial begin
    reset         = 1'b0;
    ce            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_dz", bus.div_by_zero, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    applyStimulus(28'sd1000, 12'sd7, -100, lat);
    checkOutput("p1000_p7", Q_1000_7, 6, 0, 0, 30, lat);
    applyStimulus(-28'sd1000, 12'sd7, -100, lat);
    checkOutput("m1000_p7", -Q_1000_7, -6, 0, 0, 30, lat);
    applyStimulus(28'sd1000, -12'sd7, -100, lat);
    checkOutput("p1000_m7", -Q_1000_7, 6, 0, 0, 30, lat);
    applyStimulus(-28'sd1000, -12'sd2048, -100, lat);
    checkOutput("m1000_m2048", 0, -1000, 0, 0, 30, lat);
    applyStimulus(28'sd1000, 12'sd8, -100, lat);
    checkOutput("p1000_p8", 125, 0, 0, 0, 30, lat);

    applyStimulus(28'sd134217727, 12'sd1, -100, lat);
    checkOutput("sat_pos", 32767, 0, 1, 0, 30, lat);
    applyStimulus(-28'sd134217728, 12'sd1, -100, lat);
    checkOutput("sat_neg", -32768, 0, 1, 0, 30, lat);
    applyStimulus(-28'sd32768, 12'sd1, -100, lat);
    checkOutput("edge_neg", -32768, 0, 0, 0, 30, lat);

    applyStimulus(28'sd5, 12'sd0, -100, lat);
    checkOutput("dz_pos", 32767, 0, 0, 1, 2, lat);
    applyStimulus(-28'sd5, 12'sd0, -100, lat);
    checkOutput("dz_neg", -32768, 0, 0, 1, 2, lat);

    // Backpressure: result held while out_ready is low, and ce=0 blocks the handshake.
    applyStimulus(28'sd1000, 12'sd7, -100, lat);
    bus.in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_quotient", bus.quotient, Q_1000_7);
    ce = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ce_hold", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    ce = 1'b1;
    checkOutput("bp", Q_1000_7, 6, 0, 0, 30, lat);

    // Clock-enable stall of five edges mid-CALC.
    applyStimulus(28'sd1000, 12'sd7, 10, lat);
    checkOutput("ce_stall", Q_1000_7, 6, 0, 0, 35, lat);

    // Reset ten edges into the operation.
    check("rr_in_ready", bus.in_ready, 1);
    bus.dividend = 28'sd1000;
    bus.divisor  = 12'sd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rr_busy", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    check("rr_out_valid", bus.out_valid, 0);
    check("rr_in_ready_now", bus.in_ready, 1);
    check("rr_quotient", bus.quotient, 0);
    check("rr_remainder", bus.remainder, 0);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(28'sd1000, 12'sd7, -100, lat);
    checkOutput("after_rst", Q_1000_7, 6, 0, 0, 30, lat);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
